// File: rtl/dac_segmented_core.sv
// rtl/dac_segmented_core.sv - two-stage behavioural decode core of the segmented current-steering DAC
// Optional macro DAC_COMPLEMENT_CHECK_EN enables complement-input integrity checking.
module dac_segmented_core #(
  parameter int N_BIN   = 7,
  parameter int N_THERM = 17,
  parameter int OUT_W   = 12,
  parameter int ICAL_W  = 8,
  parameter int ATB_N   = 10
) (
  input  logic                             clkin,
  input  logic                             pdb,
  input  logic                             clkinb,
  input  logic [0:N_BIN-1]                 datainbin,
  input  logic [0:N_BIN-1]                 datainbinb,
  input  logic [0:N_THERM-1]               dataintherm,
  input  logic [0:N_THERM-1]               datainthermb,
  input  logic [ICAL_W-1:0]                dataical,
  input  logic [0:ATB_N-1]                 atb_ena,
  input  logic                             vddana_0p8,
  input  logic                             vddana_1p8,
  input  logic                             vssana,
  output logic [OUT_W-1:0]                 Vout,
  output logic [OUT_W-1:0]                 Voutb,
  output logic [OUT_W-1:0]                 Ical,
  output logic [0:ATB_N-1][OUT_W-1:0]      atb,
  output logic                             err
);

  localparam int POP_W = $clog2(N_THERM + 1);
  localparam logic [OUT_W-1:0] FS = OUT_W'(N_THERM * (2 ** N_BIN) + (2 ** N_BIN) - 1);

  logic [N_BIN-1:0]   bin_q;
  logic [0:N_THERM-1] therm_q;
  logic [ICAL_W-1:0]  ical_q;
  logic [0:ATB_N-1]   ena_q;
  logic               pwr_ok_q;
  logic               hold;

  // Stage 1: capture every input; index 0 of datainbin is the MSB, so a direct copy keeps weights.
  always_ff @(posedge clkin or negedge pdb) begin
    if (!pdb) begin
      bin_q    <= '0;
      therm_q  <= '0;
      ical_q   <= '0;
      ena_q    <= '0;
      pwr_ok_q <= 1'b0;
    end else begin
      bin_q    <= datainbin;
      therm_q  <= dataintherm;
      ical_q   <= dataical;
      ena_q    <= atb_ena;
      pwr_ok_q <= vddana_0p8 & vddana_1p8 & ~vssana;
    end
  end

`ifdef DAC_COMPLEMENT_CHECK_EN
  logic cmp_bad_q;
  logic unused_clkinb;

  always_ff @(posedge clkin or negedge pdb) begin
    if (!pdb) cmp_bad_q <= 1'b0;
    else      cmp_bad_q <= (datainbinb != ~datainbin) || (datainthermb != ~dataintherm);
  end

  assign hold          = cmp_bad_q;
  assign unused_clkinb = clkinb;
`else
  logic unused_inputs;

  assign hold          = 1'b0;
  assign unused_inputs = ^{clkinb, datainbinb, datainthermb};
`endif

  logic [POP_W-1:0] pop;
  logic             contig_bad;
  logic [OUT_W-1:0] code;

  always_comb begin
    pop        = '0;
    contig_bad = 1'b0;
    for (int i = 0; i < N_THERM; i++) begin
      pop = pop + POP_W'(therm_q[i]);
    end
    // A set cell whose lower neighbour is clear breaks the fill-from-bit-0 run.
    for (int i = 1; i < N_THERM; i++) begin
      if (therm_q[i] && !therm_q[i-1]) contig_bad = 1'b1;
    end
    code = (OUT_W'(pop) << N_BIN) + OUT_W'(bin_q);
  end

  logic [OUT_W-1:0]            vout_d;
  logic [OUT_W-1:0]            voutb_d;
  logic [OUT_W-1:0]            ical_d;
  logic                        err_d;
  logic [0:ATB_N-1][OUT_W-1:0] atb_d;

  always_comb begin
    vout_d  = Vout;
    voutb_d = Voutb;
    if (!pwr_ok_q) begin
      vout_d  = '0;
      voutb_d = '0;
    end else if (!hold) begin
      vout_d  = code;
      voutb_d = FS - code;
    end
    ical_d = pwr_ok_q ? (OUT_W'(ical_q) << 4) : '0;
    err_d  = err | contig_bad | hold;
  end

  always_comb begin
    atb_d = '0;
    for (int i = 0; i < ATB_N; i++) begin
      if (ena_q[i]) begin
        case (i)
          0:       atb_d[i] = vout_d;
          1:       atb_d[i] = voutb_d;
          2:       atb_d[i] = ical_d;
          3:       atb_d[i] = code;
          4:       atb_d[i] = OUT_W'(pop);
          5:       atb_d[i] = OUT_W'(bin_q);
          6:       atb_d[i] = OUT_W'({pwr_ok_q, err_d});
          7:       atb_d[i] = OUT_W'(ical_q);
          9:       atb_d[i] = '1;
          default: atb_d[i] = '0;
        endcase
      end
    end
  end

  // Stage 2: decoded outputs and test bus share one edge.
  always_ff @(posedge clkin or negedge pdb) begin
    if (!pdb) begin
      Vout  <= '0;
      Voutb <= '0;
      Ical  <= '0;
      atb   <= '0;
      err   <= 1'b0;
    end else begin
      Vout  <= vout_d;
      Voutb <= voutb_d;
      Ical  <= ical_d;
      atb   <= atb_d;
      err   <= err_d;
    end
  end

endmodule

// File: tb/tb_dac_segmented_core.sv
// tb/tb_dac_segmented_core.sv - directed table-driven bench for dac_segmented_core
module tb_dac_segmented_core;

  logic                 clkin = 1'b0;
  logic                 clkinb;
  logic                 pdb;
  logic [0:6]           datainbin;
  logic [0:6]           datainbinb;
  logic [0:6]           binb_flip;
  logic [0:16]          dataintherm;
  logic [0:16]          datainthermb;
  logic [7:0]           dataical;
  logic [0:9]           atb_ena;
  logic                 vddana_0p8;
  logic                 vddana_1p8;
  logic                 vssana;
  logic [11:0]          Vout;
  logic [11:0]          Voutb;
  logic [11:0]          Ical;
  logic [0:9][11:0]     atb;
  logic                 err;

  int checks   = 0;
  int failures = 0;

  always #5 clkin = ~clkin;
  assign clkinb       = ~clkin;
  assign datainbinb   = ~datainbin ^ binb_flip;
  assign datainthermb = ~dataintherm;

  dac_segmented_core dut (
    .clkin        (clkin),
    .pdb          (pdb),
    .clkinb       (clkinb),
    .datainbin    (datainbin),
    .datainbinb   (datainbinb),
    .dataintherm  (dataintherm),
    .datainthermb (datainthermb),
    .dataical     (dataical),
    .atb_ena      (atb_ena),
    .vddana_0p8   (vddana_0p8),
    .vddana_1p8   (vddana_1p8),
    .vssana       (vssana),
    .Vout         (Vout),
    .Voutb        (Voutb),
    .Ical         (Ical),
    .atb          (atb),
    .err          (err)
  );

  typedef struct {
    logic [16:0]      therm;
    logic [6:0]       bin;
    logic [7:0]       ical;
    logic [9:0]       ena;
    int               vout;
    int               voutb;
    int               ical_o;
    logic [0:9][11:0] atb;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic drive(input logic [16:0] t, input logic [6:0] b, input logic [7:0] ic, input logic [9:0] en);
    dataintherm = t;
    datainbin   = b;
    dataical    = ic;
    atb_ena     = en;
  endtask

  initial begin
    int exp_q[$];
    int e;
    int n;
    logic [31:0] tw;

    vecs[0] = '{17'h00000, 7'd0,   8'h00, 10'h000, 0,    2303, 0,    '0};
    vecs[1] = '{17'h1FFFF, 7'd127, 8'hFF, 10'h000, 2303, 0,    4080, '0};
    vecs[2] = '{17'b11111111000000000, 7'd0, 8'h01, 10'h000, 1024, 1279, 16, '0};
    vecs[3] = '{17'b10000000000000000, 7'd5, 8'h00, 10'h000, 133,  2170, 0,  '0};
    vecs[4] = '{17'h00000, 7'b1000000, 8'h00, 10'h000, 64, 2239, 0, '0};
    vecs[5] = '{17'b11000000000000000, 7'd44, 8'h00, 10'b1000000001, 300, 2003, 0, '0};
    vecs[5].atb = {12'd300, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd4095};
    vecs[6] = '{17'b11111111000000000, 7'd0, 8'h3A, 10'h3FF, 1024, 1279, 928, '0};
    vecs[6].atb = {12'd1024, 12'd1279, 12'd928, 12'd1024, 12'd8, 12'd0, 12'd2, 12'd58, 12'd0, 12'd4095};

    // Reset with random data and clocks running.
    pdb        = 1'b0;
    binb_flip  = '0;
    vddana_0p8 = 1'b1;
    vddana_1p8 = 1'b1;
    vssana     = 1'b0;
    drive(17'($urandom), 7'($urandom), 8'($urandom), 10'h3FF);
    step(3);
    check("reset_vout", Vout, 0);
    check("reset_voutb", Voutb, 0);
    check("reset_ical", Ical, 0);
    check("reset_err", err, 0);
    for (int i = 0; i < 10; i++) check($sformatf("reset_atb%0d", i), atb[i], 0);

    // Release and first-sample latency.
    pdb = 1'b1;
    drive(17'h0, 7'd0, 8'h00, 10'h000);
    step(1);
    check("latency_edge1_voutb", Voutb, 0);
    step(1);
    check("release_vout", Vout, 0);
    check("release_voutb", Voutb, 2303);

    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].therm, vecs[v].bin, vecs[v].ical, vecs[v].ena);
      step(2);
      check($sformatf("vec%0d_vout", v), Vout, vecs[v].vout);
      check($sformatf("vec%0d_voutb", v), Voutb, vecs[v].voutb);
      check($sformatf("vec%0d_ical", v), Ical, vecs[v].ical_o);
      check($sformatf("vec%0d_err", v), err, 0);
      for (int i = 0; i < 10; i++)
        check($sformatf("vec%0d_atb%0d", v, i), atb[i], vecs[v].atb[i]);
    end

    // Streaming: a new code every cycle, each appearing two edges later.
    for (int k = 0; k < 26; k++) begin
      if (k >= 2) begin
        e = exp_q.pop_front();
        check($sformatf("stream%0d_vout", k - 2), Vout, e);
        check($sformatf("stream%0d_sum", k - 2), Vout + Voutb, 2303);
      end
      if (k < 24) begin
        n  = $urandom_range(0, 17);
        tw = 32'h1FFFF << (17 - n);
        e  = $urandom_range(0, 127);
        drive(tw[16:0], 7'(e), 8'h00, 10'h000);
        exp_q.push_back(128 * n + e);
      end
      step(1);
    end

    // Supply fault for three cycles on the 1.8 V rail.
    drive(17'b11100000000000000, 7'd116, 8'h10, 10'h000);
    step(2);
    check("fault_pre_vout", Vout, 500);
    check("fault_pre_ical", Ical, 256);
    vddana_1p8 = 1'b0;
    step(2);
    check("fault_vout", Vout, 0);
    check("fault_voutb", Voutb, 0);
    check("fault_ical", Ical, 0);
    step(1);
    vddana_1p8 = 1'b1;
    step(1);
    check("fault_recover_edge1_vout", Vout, 0);
    step(1);
    check("fault_recover_vout", Vout, 500);
    check("fault_recover_voutb", Voutb, 1803);
    check("fault_recover_ical", Ical, 256);

    // Non-contiguous thermometer: popcount still used, err sticks.
    drive(17'b01000000000000000, 7'd0, 8'h00, 10'h000);
    step(2);
    check("contig_vout", Vout, 128);
    check("contig_err", err, 1);
    drive(17'h0, 7'd0, 8'h00, 10'h000);
    step(2);
    check("contig_sticky_err", err, 1);
    check("contig_after_vout", Vout, 0);
    #2 pdb = 1'b0;
    #1;
    check("async_reset_err", err, 0);
    check("async_reset_voutb", Voutb, 0);
    @(negedge clkin);
    pdb = 1'b1;
    step(2);
    check("post_reset_voutb", Voutb, 2303);

`ifdef DAC_COMPLEMENT_CHECK_EN
    drive(17'b10000000000000000, 7'd72, 8'h00, 10'h000);
    step(2);
    check("cmp_pre_vout", Vout, 200);
    drive(17'b11111000000000000, 7'd60, 8'h00, 10'h000);
    binb_flip = 7'b0000001;
    step(2);
    check("cmp_hold_vout", Vout, 200);
    check("cmp_hold_voutb", Voutb, 2103);
    check("cmp_err", err, 1);
    binb_flip = '0;
    step(2);
    check("cmp_resume_vout", Vout, 700);
    check("cmp_sticky_err", err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
